// File: rtl/maxnet_engine.sv
// Winner-take-all (MaxNet) iteration engine: serial summation, parallel lateral inhibition.
// Optional MAXNET_TIE_BREAK_EN: report the lowest surviving lane when an update zeroes every lane.
module maxnet_engine #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EPS_SHIFT = 2,
  parameter int unsigned MAX_ITER  = 16,
  parameter int unsigned ITER_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*WIDTH-1:0]     act_in,
  output logic                   busy,
  output logic                   done,
  output logic                   winner_valid,
  output logic [$clog2(N)-1:0]   winner_idx,
  output logic [WIDTH-1:0]       winner_value,
  output logic [ITER_W-1:0]      iter_count,
  output logic                   timeout
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned ACC_W = WIDTH + $clog2(N);
  localparam int unsigned NZ_W  = $clog2(N + 1);

  localparam logic [IDX_W-1:0]  LastK   = IDX_W'(N - 1);
  localparam logic [ITER_W-1:0] IterMax = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    StIdle, StLoad, StCheck, StSum, StUpdate, StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lane_q [N];
  logic [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0] k_q;

  logic [NZ_W-1:0]  nz;
  logic [IDX_W-1:0] nz_idx;
  logic [WIDTH-1:0] nz_val;
  logic [ACC_W-1:0] inh [N];
  logic [WIDTH-1:0] lane_upd [N];

  // Lowest-index non-zero lane falls out of a descending scan (last hit wins).
  always_comb begin
    nz     = '0;
    nz_idx = '0;
    nz_val = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (lane_q[i] != '0) begin
        nz     = nz + 1'b1;
        nz_idx = IDX_W'(i);
        nz_val = lane_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      inh[i]      = (acc_q - ACC_W'(lane_q[i])) >> EPS_SHIFT;
      lane_upd[i] = (ACC_W'(lane_q[i]) > inh[i]) ? lane_q[i] - inh[i][WIDTH-1:0] : '0;
    end
  end

`ifdef MAXNET_TIE_BREAK_EN
  logic [WIDTH-1:0] snap_q [N];
  logic             snap_any;
  logic [IDX_W-1:0] snap_idx;
  logic [WIDTH-1:0] snap_val;

  always_comb begin
    snap_any = 1'b0;
    snap_idx = '0;
    snap_val = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (snap_q[i] != '0) begin
        snap_any = 1'b1;
        snap_idx = IDX_W'(i);
        snap_val = snap_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (state_q == StLoad) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (state_q == StUpdate) begin
      for (int i = 0; i < N; i++) snap_q[i] <= lane_q[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      for (int i = 0; i < N; i++) lane_q[i] <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
      winner_value <= '0;
      iter_count   <= '0;
      timeout      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          for (int i = 0; i < N; i++) lane_q[i] <= act_in[i*WIDTH +: WIDTH];
          iter_count   <= '0;
          timeout      <= 1'b0;
          winner_valid <= 1'b0;
          winner_idx   <= '0;
          winner_value <= '0;
          state_q      <= StCheck;
        end
        StCheck: begin
          if (nz <= NZ_W'(1)) begin
            if (nz == NZ_W'(1)) begin
              winner_valid <= 1'b1;
              winner_idx   <= nz_idx;
              winner_value <= nz_val;
            end
`ifdef MAXNET_TIE_BREAK_EN
            else if (snap_any) begin
              winner_valid <= 1'b1;
              winner_idx   <= snap_idx;
              winner_value <= snap_val;
            end
`endif
            done    <= 1'b1;
            state_q <= StDone;
          end else if (iter_count == IterMax) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StSum;
          end
        end
        StSum: begin
          acc_q <= acc_q + ACC_W'(lane_q[k_q]);
          if (k_q == LastK) begin
            state_q <= StUpdate;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StUpdate: begin
          for (int i = 0; i < N; i++) lane_q[i] <= lane_upd[i];
          iter_count <= iter_count + 1'b1;
          state_q    <= StCheck;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/maxnet_engine.md
Name: maxnet_engine

Overview:
- Parametrised winner-take-all (MaxNet) iteration engine; generalises the fixed controller/datapath pair to N lanes, configurable width, inhibition factor and iteration bound.
- Loads N unsigned activations, repeatedly applies mutual inhibition until at most one lane is non-zero or an iteration limit is reached, then reports the winning lane.
- Controller FSM and lane datapath live in one module; sits behind the top-level start/done handshake.

Parameters:
- N, 4, lane count (>=2).
- WIDTH, 8, activation width, unsigned.
- EPS_SHIFT, 2, inhibition factor eps = 2^-EPS_SHIFT; 0 means eps = 1.
- MAX_ITER, 16, iteration bound (>=1).
- ITER_W, 8, iteration counter width (2^ITER_W > MAX_ITER).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  start request, sampled in IDLE only.
- act_in  in  N*WIDTH  initial activations; lane i = act_in[i*WIDTH +: WIDTH].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- winner_valid  out  1  a single winner exists.
- winner_idx  out  clog2(N)  winning lane.
- winner_value  out  WIDTH  final activation of the winner.
- iter_count  out  ITER_W  iterations executed.
- timeout  out  1  stopped because MAX_ITER was reached.

Behaviour:
- Reset (async, any state): state=IDLE, all activations, accumulator, lane counter, iter_count and every output = 0.
- FSM states:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): latch act_in into lane registers; clear iter_count and timeout.
  - CHECK (1 cycle): nz = number of non-zero lanes. nz<=1 -> DONE. Else iter_count==MAX_ITER -> set timeout, DONE. Else clear accumulator and lane counter -> SUM.
  - SUM (N cycles): acc += a[k], k=0..N-1 serially; after k=N-1 -> UPDATE.
  - UPDATE (1 cycle): all lanes in parallel: inh_i = (acc - a_i) >> EPS_SHIFT; a_i <= (a_i > inh_i) ? a_i - inh_i : 0; iter_count++ -> CHECK.
  - DONE (1 cycle): done=1 -> IDLE.
- Widths: acc is WIDTH+clog2(N) bits, no overflow; activations never go negative.
- Result outputs are updated on entry to DONE and held until the next LOAD.
  - nz==1: winner_valid=1, winner_idx = that lane, winner_value = its activation.
  - nz==0 or timeout with nz>1: winner_valid=0, winner_idx=0, winner_value=0 (see optional feature).
- Latency: done asserts 2 + k*(N+2) cycles after the edge that samples start, where k = iterations run.
- start while busy: ignored; act_in is only sampled in LOAD.
- rst mid-run: immediate return to IDLE with all outputs cleared; the next start runs a full fresh job.

Optional Feature:
- Macro: MAXNET_TIE_BREAK_EN.
- Defined: the engine snapshots the lane values present before each UPDATE. If a CHECK finds nz==0, it reports winner_valid=1, winner_idx = lowest-index lane that was non-zero in the snapshot, and winner_value = that lane's snapshot value.
- Not defined: nz==0 gives winner_valid=0, as in Behaviour; no snapshot registers are built.
- Timeout behaviour is unchanged in both builds.

Test Plan:
- N=4, WIDTH=8, EPS_SHIFT=2, act_in={10,20,30,40} (lane0..3): lane values after each iteration are {0,0,13,25}, {0,0,7,22}, {0,0,2,21}, {0,0,0,21} -> done 26 cycles after start; winner_valid=1, idx=3, value=21, iter_count=4, timeout=0.
- act_in={0,0,55,0}: done 2 cycles after start; idx=2, value=55, iter_count=0, winner_valid=1.
- EPS_SHIFT=0, act_in={50,50,0,0}: after 1 iteration all lanes are 0.
  - Without macro: winner_valid=0.
  - With MAXNET_TIE_BREAK_EN: winner_valid=1, idx=0, value=50, iter_count=1.
- EPS_SHIFT=1, MAX_ITER=16, act_in={50,50,0,0}: lanes settle at {1,1,0,0} -> timeout=1, iter_count=16, winner_valid=0, done 2+16*6=98 cycles after start.
- Assert rst 10 cycles into the first scenario: busy, done and all results read 0 immediately. A fresh start then reproduces the first scenario's results exactly. A start pulse issued while busy has no effect.
